coin_acceptor: RTL and testbench

- Front-end coin and cancel conditioner that drives the vending FSM's one-clock-pulse inputs `nickel`, `dime`, `quarter` and `cancel`.
- Synchronises and qualifies raw coin-mechanism and button signals, and rejects slugs and glitches.
- Queues accepted coins while the vending FSM is busy dispensing, then replays them as single-cycle pulses with a guaranteed minimum spacing.
- Sits between the coin mechanism and the vending FSM; the FSM's `candy`/`n`/`d` outputs are ORed at top level into `busy`.

---
 rtl/coin_acceptor.sv | 258 +++++++++++++++++++++++++
 tb/tb_coin_acceptor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises and qualifies raw coin, slug and cancel inputs.
// Accepted coins are queued while the vending FSM is busy. They are then
// replayed as single-cycle pulses, with MIN_GAP idle cycles after every pulse.
// Build option: define COIN_FIFO_EN for a FIFO_DEPTH-entry coin queue.
// Without it, a single holding register is used (depth 1).
module coin_acceptor #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int MIN_GAP       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    coin_sense,
  input  logic                          slug_sense,
  input  logic                          cancel_btn,
  input  logic                          busy,
  output logic                          nickel,
  output logic                          dime,
  output logic                          quarter,
  output logic                          cancel,
  output logic                          coin_return,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;
`ifdef COIN_FIFO_EN
  localparam int QDEPTH = FIFO_DEPTH;
`else
  localparam int QDEPTH = 1;
`endif
  localparam logic [PW-1:0] QFULL       = PW'(QDEPTH);
  localparam logic [3:0]    STABLE_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [2:0]    GAP_LOAD    = 3'(MIN_GAP);

  typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, WAIT_REL = 2'd2} qstate_t;

  // synchroniser flops
  logic [1:0] coin_m_r, coin_s_r;
  logic       slug_m_r, slug_s_r;
  logic       cancel_m_r, cancel_s_r;

  // qualifier FSM
  qstate_t    state_r, state_nx;
  logic [1:0] code_r, code_nx;
  logic [3:0] qcnt_r, qcnt_nx;
  logic       push_req_s, slug_ret_s;

  // queue and emitter
  logic [PW-1:0] count_r;
  logic [1:0]    head_s;
  logic          push_ok_s, ovf_s, slot_s, pop_s, cancel_emit_s;
  logic [2:0]    gap_r;

  // cancel debounce
  logic       deb_r, cancel_req_r, rise_s;
  logic [3:0] dcnt_r;

  // Two-flop synchronisers for every raw input from the mechanism and button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_m_r   <= 2'b00;
      coin_s_r   <= 2'b00;
      slug_m_r   <= 1'b0;
      slug_s_r   <= 1'b0;
      cancel_m_r <= 1'b0;
      cancel_s_r <= 1'b0;
    end else begin
      coin_m_r   <= coin_sense;
      coin_s_r   <= coin_m_r;
      slug_m_r   <= slug_sense;
      slug_s_r   <= slug_m_r;
      cancel_m_r <= cancel_btn;
      cancel_s_r <= cancel_m_r;
    end
  end

  // Qualifier FSM state, held code and stability/release counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      code_r  <= 2'b00;
      qcnt_r  <= 4'd0;
    end else begin
      state_r <= state_nx;
      code_r  <= code_nx;
      qcnt_r  <= qcnt_nx;
    end
  end

  // Qualifier next state. In QUAL, a slug wins over everything else. The push
  // fires on the edge where the count would reach STABLE_CYCLES.
  always_comb begin
    state_nx   = state_r;
    code_nx    = code_r;
    qcnt_nx    = qcnt_r;
    push_req_s = 1'b0;
    slug_ret_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (coin_s_r != 2'b00) begin
          state_nx = QUAL;
          code_nx  = coin_s_r;
          qcnt_nx  = 4'd1;
        end else begin
          qcnt_nx  = 4'd0;
        end
      end
      QUAL: begin
        if (slug_s_r) begin
          slug_ret_s = 1'b1;
          state_nx   = WAIT_REL;
          qcnt_nx    = 4'd0;
        end else if (coin_s_r == 2'b00) begin
          state_nx   = IDLE;
          qcnt_nx    = 4'd0;
        end else if (coin_s_r != code_r) begin
          code_nx    = coin_s_r;
          qcnt_nx    = 4'd1;
        end else if (qcnt_r == STABLE_LAST) begin
          push_req_s = 1'b1;
          state_nx   = WAIT_REL;
          qcnt_nx    = 4'd0;
        end else begin
          qcnt_nx    = qcnt_r + 4'd1;
        end
      end
      WAIT_REL: begin
        if (coin_s_r != 2'b00) begin
          qcnt_nx  = 4'd0;
        end else if (qcnt_r == STABLE_LAST) begin
          state_nx = IDLE;
          qcnt_nx  = 4'd0;
        end else begin
          qcnt_nx  = qcnt_r + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        code_nx  = 2'b00;
        qcnt_nx  = 4'd0;
      end
    endcase
  end

  // Queue control and emission decision. Coins take priority over cancel, so
  // all credit reaches the vending FSM before the refund request.
  always_comb begin
    push_ok_s     = push_req_s && (count_r != QFULL);
    ovf_s         = push_req_s && (count_r == QFULL);
    slot_s        = !busy && (gap_r == 3'd0);
    pop_s         = slot_s && (count_r != {PW{1'b0}});
    cancel_emit_s = slot_s && (count_r == {PW{1'b0}}) && cancel_req_r;
    rise_s        = cancel_s_r && !deb_r && (dcnt_r == STABLE_LAST);
  end

`ifdef COIN_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  logic [1:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;

  // Circular coin queue. Both pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 2'b00;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= code_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  assign head_s = mem_r[rd_ptr_r];
`else
  logic [1:0] hold_r;

  // Single holding register. Its occupancy is tracked by count_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r <= 2'b00;
    end else if (push_ok_s) begin
      hold_r <= code_r;
    end
  end

  assign head_s = hold_r;
`endif

  // Occupancy count. A simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {PW{1'b0}};
    end else begin
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + PW'(1);
        2'b01:   count_r <= count_r - PW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign pending = count_r;

  // Cancel debounce. A level change is accepted after STABLE_CYCLES stable cycles.
  // A rising edge latches a request; further edges are absorbed until the request is emitted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_r        <= 1'b0;
      dcnt_r       <= 4'd0;
      cancel_req_r <= 1'b0;
    end else begin
      if (cancel_s_r != deb_r) begin
        if (dcnt_r == STABLE_LAST) begin
          deb_r  <= cancel_s_r;
          dcnt_r <= 4'd0;
        end else begin
          dcnt_r <= dcnt_r + 4'd1;
        end
      end else begin
        dcnt_r <= 4'd0;
      end
      if (rise_s) begin
        cancel_req_r <= 1'b1;
      end else if (cancel_emit_s) begin
        cancel_req_r <= 1'b0;
      end
    end
  end

  // Registered output pulses and the post-emission gap counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nickel      <= 1'b0;
      dime        <= 1'b0;
      quarter     <= 1'b0;
      cancel      <= 1'b0;
      coin_return <= 1'b0;
      gap_r       <= 3'd0;
    end else begin
      nickel      <= pop_s && (head_s == 2'b01);
      dime        <= pop_s && (head_s == 2'b10);
      quarter     <= pop_s && (head_s == 2'b11);
      cancel      <= cancel_emit_s;
      coin_return <= slug_ret_s || ovf_s;
      if (pop_s || cancel_emit_s) begin
        gap_r <= GAP_LOAD;
      end else if (gap_r != 3'd0) begin
        gap_r <= gap_r - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor, using default parameters.
// Expected values follow COIN_FIFO_EN: depth 4 when it is defined, otherwise depth 1.
module tb_coin_acceptor;

`ifdef COIN_FIFO_EN
  localparam int QD = 4;
`else
  localparam int QD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] coin_sense = 2'b00;
  logic       slug_sense = 1'b0;
  logic       cancel_btn = 1'b0;
  logic       busy = 1'b0;
  logic       nickel, dime, quarter, cancel, coin_return;
  logic [2:0] pending;

  coin_acceptor dut (
    .clk(clk), .rst(rst), .coin_sense(coin_sense), .slug_sense(slug_sense),
    .cancel_btn(cancel_btn), .busy(busy), .nickel(nickel), .dime(dime),
    .quarter(quarter), .cancel(cancel), .coin_return(coin_return), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] coin;
    logic       slug;
    logic       cbtn;
    logic       bsy;
    logic [7:0] exp;   // {nickel,dime,quarter,cancel,coin_return,pending[2:0]}
  } vec_t;

  vec_t vecs[30];
  int   n_pass = 0;
  int   n_total = 0;

  // pulse monitor, sampled on the falling edge
  int cyc_n = 0, nick_n = 0, dime_n = 0, quar_n = 0, canc_n = 0, ret_n = 0, multi_n = 0;
  int dime_t = 0, canc_t = 0;
  int nick_t[16];

  always @(negedge clk) begin
    cyc_n <= cyc_n + 1;
    if (nickel) begin
      nick_t[nick_n & 15] <= cyc_n;
      nick_n <= nick_n + 1;
    end
    if (dime) begin
      dime_n <= dime_n + 1;
      dime_t <= cyc_n;
    end
    if (quarter) quar_n <= quar_n + 1;
    if (cancel) begin
      canc_n <= canc_n + 1;
      canc_t <= cyc_n;
    end
    if (coin_return) ret_n <= ret_n + 1;
    if ((32'(nickel) + 32'(dime) + 32'(quarter)) > 32'd1) multi_n <= multi_n + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [7:0] outs();
    return {nickel, dime, quarter, cancel, coin_return, pending};
  endfunction

  task automatic insert_coin(input logic [1:0] code);
    coin_sense = code;
    repeat (8) cyc();
    coin_sense = 2'b00;
    repeat (10) cyc();
  endtask

  initial begin
    int r0, n0, d0, q0, c0;
    // Single dime: 8 cycles of code 10. pending is 1 after edge 5 and the dime is high
    // after edge 6. The glitch follows: 3 cycles of code 11, which is never accepted.
    for (int i = 0; i < 30; i++) begin
      vecs[i].coin = (i < 8) ? 2'b10 : ((i >= 16 && i < 19) ? 2'b11 : 2'b00);
      vecs[i].slug = 1'b0;
      vecs[i].cbtn = 1'b0;
      vecs[i].bsy  = 1'b0;
      vecs[i].exp  = (i == 5) ? 8'h01 : ((i == 6) ? 8'h40 : 8'h00);
    end

    // reset
    repeat (3) cyc();
    check("reset_outputs", int'(outs()), 0);
    rst = 1'b1;
    cyc();
    check("after_reset_outputs", int'(outs()), 0);

    // table: single dime + glitch
    for (int i = 0; i < 30; i++) begin
      coin_sense = vecs[i].coin;
      slug_sense = vecs[i].slug;
      cancel_btn = vecs[i].cbtn;
      busy       = vecs[i].bsy;
      cyc();
      if (outs() !== vecs[i].exp)
        $display("FAIL vec%0d: got %h expected %h", i, outs(), vecs[i].exp);
      else n_pass++;
      n_total++;
    end
    check("dime_count_table", dime_n, 1);
    check("return_count_table", ret_n, 0);

    // backpressure: 3 nickels while busy
    busy = 1'b1;
    r0 = ret_n; n0 = nick_n;
    repeat (3) insert_coin(2'b01);
    check("bp_pending", int'(pending), (QD >= 3) ? 3 : QD);
    check("bp_no_pulses", nick_n - n0, 0);
    check("bp_returns", ret_n - r0, (QD >= 3) ? 0 : 3 - QD);
    busy = 1'b0;
    repeat (15) cyc();
    check("bp_nickels", nick_n - n0, (QD >= 3) ? 3 : QD);
    check("bp_pending_drained", int'(pending), 0);
`ifdef COIN_FIFO_EN
    check("bp_spacing1", nick_t[(n0 + 1) & 15] - nick_t[n0 & 15], 3);
    check("bp_spacing2", nick_t[(n0 + 2) & 15] - nick_t[(n0 + 1) & 15], 3);
`endif

    // overflow: 5 quarters while busy
    busy = 1'b1;
    r0 = ret_n; q0 = quar_n;
    repeat (5) insert_coin(2'b11);
    check("ovf_pending", int'(pending), QD);
    check("ovf_returns", ret_n - r0, 5 - QD);
    busy = 1'b0;
    repeat (20) cyc();
    check("ovf_quarters", quar_n - q0, QD);
    check("ovf_pending_drained", int'(pending), 0);

    // slug during QUAL of a dime, then the release rule
    r0 = ret_n; d0 = dime_n;
    coin_sense = 2'b10;
    cyc();
    slug_sense = 1'b1;
    repeat (2) cyc();
    slug_sense = 1'b0;
    repeat (9) cyc();
    coin_sense = 2'b00;
    repeat (2) cyc();
    coin_sense = 2'b10;
    repeat (2) cyc();
    coin_sense = 2'b00;
    repeat (10) cyc();
    check("slug_return", ret_n - r0, 1);
    check("slug_no_dime", dime_n - d0, 0);
    check("slug_pending", int'(pending), 0);
    insert_coin(2'b10);
    check("slug_then_accept", dime_n - d0, 1);

    // ordering: dime queued, cancel held, then busy released
    busy = 1'b1;
    d0 = dime_n; c0 = canc_n;
    insert_coin(2'b10);
    cancel_btn = 1'b1;
    repeat (6) cyc();
    cancel_btn = 1'b0;
    repeat (10) cyc();
    check("ord_pending", int'(pending), 1);
    check("ord_no_cancel_yet", canc_n - c0, 0);
    busy = 1'b0;
    repeat (10) cyc();
    check("ord_dime", dime_n - d0, 1);
    check("ord_cancel", canc_n - c0, 1);
    check("ord_cancel_spacing", canc_t - dime_t, 3);

    // reset while a coin is pending
    busy = 1'b1;
    d0 = dime_n;
    insert_coin(2'b10);
    check("rst_pre_pending", int'(pending), 1);
    rst = 1'b0;
    #1;
    check("rst_async_outputs", int'(outs()), 0);
    repeat (2) cyc();
    rst = 1'b1;
    busy = 1'b0;
    repeat (15) cyc();
    check("rst_no_dime", dime_n - d0, 0);
    check("rst_pending", int'(pending), 0);

    check("one_hot_coins", multi_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
